// File: rtl/demux14_scan_pkg.sv
// Shared definitions for the 1-to-N scan/addressed demultiplexer.
// Holds the mode encodings and the default select width.
package demux14_scan_pkg;

  localparam int SEL_W_DEFAULT = 2;

  typedef enum logic {
    MODE_SCAN = 1'b0,
    MODE_ADDR = 1'b1
  } mode_e;

endpackage : demux14_scan_pkg

// File: rtl/demux14_scan.sv
// 1-to-N bit distributor: a serial bit stream is deserialised into a registered
// N-slot word, either by an internal scan counter or by an external slot address.
module demux14_scan
  import demux14_scan_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        S,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    sync_clr,
  output logic [(2**SEL_W)-1:0]   Y,
  output logic                    frame_done,
  output logic [SEL_W-1:0]        slot,
  output logic                    busy
);

  localparam int N_SLOTS = 2 ** SEL_W;

  logic               addr_mode;
  logic               scan_write;
  logic               last_slot;

  logic [SEL_W-1:0]   slot_d,       slot_q;
  logic               frame_done_d, frame_done_q;
  logic [N_SLOTS-1:0] shadow_d,     shadow_q;
  logic [N_SLOTS-1:0] y_d,          y_q;

  // sync_clr outranks both modes; addressed mode outranks scan writes.
  assign addr_mode  = (mode == MODE_ADDR);
  assign scan_write = !sync_clr && !addr_mode && din_valid;
  assign last_slot  = (slot_q == SEL_W'(N_SLOTS - 1));

  // Slot counter and frame-commit strobe.
  always_comb begin
    slot_d       = slot_q;
    frame_done_d = 1'b0;
    if (sync_clr || addr_mode) begin
      slot_d = '0;
    end else if (din_valid) begin
      slot_d       = slot_q + SEL_W'(1);
      frame_done_d = last_slot;
    end
  end

  // NOTE: reset is synchronous here, so rst sits inside the clocked block and
  // is not in the sensitivity list; every state register uses <= so all flops
  // update together from values computed before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Shadow collects the partial frame; Y only changes on a full-frame commit
  // or an addressed write, so partial frames are never visible.
  always_comb begin
    shadow_d = shadow_q;
    y_d      = y_q;
    if (!sync_clr && din_valid) begin
      if (addr_mode) begin
        shadow_d[S] = din;
        y_d[S]      = din;
      end else if (scan_write) begin
        shadow_d[slot_q] = din;
        if (last_slot) begin
          y_d = shadow_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      y_q      <= '0;
    end else begin
      shadow_q <= shadow_d;
      y_q      <= y_d;
    end
  end

  assign Y          = y_q;
  assign frame_done = frame_done_q;
  assign slot       = slot_q;
  assign busy       = (slot_q != '0);

endmodule : demux14_scan

// File: tb/tb_demux14_scan.sv
// Scoreboard bench for demux14_scan: a frame-level reference model predicts
// each cycle's outputs and every committed word; a monitor compares them.
module tb_demux14_scan;

  localparam int SEL_W   = 2;
  localparam int N_SLOTS = 2 ** SEL_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               mode;
  logic [SEL_W-1:0]   S;
  logic               din;
  logic               din_valid;
  logic               sync_clr;
  logic [N_SLOTS-1:0] Y;
  logic               frame_done;
  logic [SEL_W-1:0]   slot;
  logic               busy;

  demux14_scan #(.SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .S          (S),
    .din        (din),
    .din_valid  (din_valid),
    .sync_clr   (sync_clr),
    .Y          (Y),
    .frame_done (frame_done),
    .slot       (slot),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_SLOTS-1:0] y;
    int                 slot;
    logic               busy;
    logic               fd;
  } exp_t;

  exp_t               exp_q[$];
  logic [N_SLOTS-1:0] frame_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: committed word plus the bits of the open frame.
  logic [N_SLOTS-1:0] m_y  = '0;
  logic               m_fd = 1'b0;
  logic               m_bits[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Apply one cycle of stimulus and record what the DUT must show after the edge.
  task automatic step(input logic r, input logic m, input logic [SEL_W-1:0] s,
                      input logic d, input logic v, input logic c);
    exp_t               e;
    logic [N_SLOTS-1:0] w;
    @(negedge clk);
    rst = r; mode = m; S = s; din = d; din_valid = v; sync_clr = c;
    m_fd = 1'b0;
    if (r) begin
      m_y = '0;
      m_bits.delete();
    end else if (c) begin
      m_bits.delete();
    end else if (m) begin
      m_bits.delete();
      if (v) m_y[s] = d;
    end else if (v) begin
      m_bits.push_back(d);
      if (m_bits.size() == N_SLOTS) begin
        for (int i = 0; i < N_SLOTS; i++) w[i] = m_bits[i];
        m_y  = w;
        m_fd = 1'b1;
        frame_q.push_back(w);
        m_bits.delete();
      end
    end
    e.y    = m_y;
    e.slot = m_bits.size();
    e.busy = (m_bits.size() != 0);
    e.fd   = m_fd;
    exp_q.push_back(e);
  endtask

  task automatic scan_bits(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, bits[i], 1'b1, 1'b0);
  endtask

  task automatic idle(input logic m);
    step(1'b0, m, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one expected record per cycle; committed words popped on frame_done.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("y",          32'(Y),          32'(e.y));
        check("slot",       32'(slot),       32'(e.slot));
        check("busy",       32'(busy),       32'(e.busy));
        check("frame_done", 32'(frame_done), 32'(e.fd));
        if (frame_done === 1'b1) begin
          if (frame_q.size() == 0) begin
            n_checks++;
            $display("FAIL frame_word: unexpected frame_done, Y=%0h at %0t", Y, $time);
          end else begin
            check("frame_word", 32'(Y), 32'(frame_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    logic r, m, v, c;
    rst = 1'b1; mode = 1'b0; S = '0; din = 1'b1; din_valid = 1'b1; sync_clr = 1'b0;

    // Reset held two cycles with valid data present.
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Scan frame 1,0,1,1 -> 1101.
    scan_bits(8'b1101, 4);
    idle(1'b0);
    idle(1'b0);

    // Two bits, sync_clr with a concurrent valid, then 0,0,0,1 -> 1000.
    scan_bits(8'b11, 2);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    scan_bits(8'b1000, 4);
    idle(1'b0);

    // Addressed writes.
    step(1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);

    // Mode switch mid-frame discards the partial frame.
    scan_bits(8'b11, 2);
    idle(1'b1);
    scan_bits(8'b0010, 4);
    idle(1'b0);

    // Twelve back-to-back bits: three frames, four cycles apart.
    scan_bits(8'b0110_1001, 8);
    scan_bits(8'b1010, 4);
    idle(1'b0);

    // Reset in the middle of a frame.
    scan_bits(8'b111, 3);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(99) < 2);
      m = ($urandom_range(99) < 20);
      v = ($urandom_range(99) < 75);
      c = ($urandom_range(99) < 5);
      step(r, m, SEL_W'($urandom), 1'($urandom), v, c);
    end
    idle(1'b0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    check("exp_queue_drained",   32'(exp_q.size()),   32'd0);
    check("frame_queue_drained", 32'(frame_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_demux14_scan
